// File: rtl/muldiv_seq_if.sv
// Execute-stage <-> HI/LO sequencer bundle: operation request in, HI/LO and status out.
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hilo_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dz;

  modport master (output start, op, a, b, flush, hilo_req,
                  input  hi, lo, busy, stall, done, dz);
  modport slave  (input  start, op, a, b, flush, hilo_req,
                  output hi, lo, busy, stall, done, dz);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned multu/divu sequencer owning HI/LO; 32 shift-add / restoring-subtract steps
// on private working registers, with mthi/mtlo writing HI/LO directly.
module muldiv_seq (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;

  state_t      r_state, w_state_n;
  logic [4:0]  r_cnt, w_cnt_n;
  logic [31:0] r_acc, w_acc_n;
  logic [31:0] r_q, w_q_n;
  logic [31:0] r_m, w_m_n;
  logic [31:0] r_hi, w_hi_n;
  logic [31:0] r_lo, w_lo_n;
  logic        r_done, w_done_n;
  logic        r_dz, w_dz_n;

  logic [32:0] w_mul_t;
  logic [32:0] w_div_r;

  assign w_mul_t = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : 33'd0);
  assign w_div_r = {r_acc, r_q[31]} - {1'b0, r_m};

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_acc_n   = r_acc;
    w_q_n     = r_q;
    w_m_n     = r_m;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_done_n  = 1'b0;
    w_dz_n    = r_dz;
    case (r_state)
      IDLE: begin
        // A flush in the same cycle kills the request before it is accepted.
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MULTU, OP_DIVU: begin
              w_m_n     = bus.b;
              w_q_n     = bus.a;
              w_acc_n   = '0;
              w_cnt_n   = '0;
              w_dz_n    = (bus.op == OP_DIVU) && (bus.b == '0);
              w_state_n = (bus.op == OP_MULTU) ? MUL : DIV;
            end
            OP_MTHI: w_hi_n = bus.a;
            default: w_lo_n = bus.a;
          endcase
        end
      end
      MUL, DIV: begin
        if (bus.flush) begin
          w_state_n = IDLE;
          w_dz_n    = 1'b0;
        end else begin
          if (r_state == MUL) begin
            {w_acc_n, w_q_n} = {w_mul_t, r_q[31:1]};
          end else if (!w_div_r[32]) begin
            w_acc_n = w_div_r[31:0];
            w_q_n   = {r_q[30:0], 1'b1};
          end else begin
            w_acc_n = {r_acc[30:0], r_q[31]};
            w_q_n   = {r_q[30:0], 1'b0};
          end
          w_cnt_n = r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            w_hi_n    = w_acc_n;
            w_lo_n    = w_q_n;
            w_done_n  = 1'b1;
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_acc   <= w_acc_n;
      r_q     <= w_q_n;
      r_m     <= w_m_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_done  <= w_done_n;
      r_dz    <= w_dz_n;
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = (r_state != IDLE);
  assign bus.stall = bus.busy & bus.hilo_req;
  assign bus.done  = r_done;
  assign bus.dz    = r_dz;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboarded random bench for muldiv_seq; expected HI/LO come from plain 64-bit arithmetic.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_seq_if bus();
  muldiv_seq dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding multu/divu result.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done (hi=%h lo=%h)", bus.hi, bus.lo);
      end else begin
        e = sb.pop_front();
        chk("done_hi", {32'd0, bus.hi}, {32'd0, e.hi});
        chk("done_lo", {32'd0, bus.lo}, {32'd0, e.lo});
        chk("done_dz", {63'd0, bus.dz}, {63'd0, e.dz});
      end
    end
  end

  // Drive one request for one cycle starting at a negedge; update the model if the op should commit.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit commit);
    logic [63:0] p;
    exp_t        e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (commit) begin
      case (op)
        2'b00: begin
          p = {32'd0, a} * {32'd0, b};
          m_hi = p[63:32];
          m_lo = p[31:0];
        end
        2'b01: begin
          if (b == 0) begin
            m_hi = a;
            m_lo = 32'hFFFF_FFFF;
          end else begin
            m_hi = a % b;
            m_lo = a / b;
          end
        end
        2'b10: m_hi = a;
        default: m_lo = a;
      endcase
      if (op[1] == 1'b0) begin
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = (op == 2'b01) && (b == 0);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (bus.busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (bus.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected busy=0", c);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int          c;
    logic [1:0]  op;
    logic [31:0] ra, rb;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0; bus.hilo_req = 0;

    // Reset state
    wait_cycles(2);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_flags", {60'd0, bus.busy, bus.stall, bus.done, bus.dz}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // multu max x max, with busy length
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_idle(c);
    chk("mul_busy_cycles", 64'(c), 64'd32);
    chk("mul_max_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    // divu 100/7 then back-to-back 7/100 issued in the done cycle
    issue(2'b01, 32'd100, 32'd7, 1);
    wait_idle(c);
    chk("div_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
    issue(2'b01, 32'd7, 32'd100, 1);
    wait_idle(c);
    chk("div_7_100", {bus.hi, bus.lo}, {32'd7, 32'd0});

    // divide by zero, then multu clears dz
    issue(2'b01, 32'h0000_1234, 32'd0, 1);
    wait_idle(c);
    chk("divz_dz", {63'd0, bus.dz}, 64'd1);
    issue(2'b00, 32'd3, 32'd5, 1);
    chk("dz_cleared_on_start", {63'd0, bus.dz}, 64'd0);
    wait_idle(c);
    chk("mul_3_5", {bus.hi, bus.lo}, {32'd0, 32'd15});

    // mthi then flushed multu
    issue(2'b10, 32'h0000_AAAA, 32'd0, 1);
    chk("mthi", {32'd0, bus.hi}, 64'h0000_AAAA);
    issue(2'b00, 32'd2, 32'd3, 0);
    wait_cycles(9);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {63'd0, bus.busy}, 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, {32'h0000_AAAA, m_lo});
    chk("flush_dz", {63'd0, bus.dz}, 64'd0);
    wait_cycles(40);

    // stall during multu, stray start at iteration 5 ignored
    bus.hilo_req = 1'b1;
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    c = 0;
    while (bus.busy && c < 40) begin
      chk("stall_busy", {63'd0, bus.stall}, 64'd1);
      bus.start = (c == 5);
      bus.op    = 2'b01;
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    chk("stall_busy_cycles", 64'(c), 64'd32);
    chk("stall_done_cycle", {62'd0, bus.stall, bus.done}, 64'd1);
    bus.hilo_req = 1'b0;

    // asynchronous reset mid-divide
    bus.hilo_req = 1'b1;
    issue(2'b01, $urandom, $urandom_range(1, 1000), 1);
    wait_cycles(19);
    reset = 1'b0;
    #1;
    chk("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midop_reset_flags", {60'd0, bus.busy, bus.stall, bus.done, bus.dz}, 64'd0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    bus.hilo_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(2'b11, 32'd5, 32'd0, 1);
    chk("mtlo_after_reset", {bus.hi, bus.lo}, {32'd0, 32'd5});

    // random mix, multu/divu issued back-to-back in done cycles
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      issue(op, ra, rb, 1);
      if (op[1] == 1'b0) wait_idle(c);
      else chk("rand_mtx", {bus.hi, bus.lo}, {m_hi, m_lo});
    end

    wait_cycles(3);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative unsigned multiply/divide sequencer owning the HI/LO register pair for the pipelined MIPS core. It accepts `multu`, `divu`, `mthi` and `mtlo` operations from the execute stage. Multiply and divide run for 32 cycles on a private shift-add/subtract datapath. While an operation is in flight, the block raises a stall to the pipeline enables/clears whenever decode needs HI/LO.

## Interface
Parameters:
- none (fixed 32-bit operands; iteration count fixed at 32)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- start  input  1  operation request from execute stage, sampled on rising clk
- op  input  2  00 multu, 01 divu, 10 mthi, 11 mtlo
- a  input  32  rs operand (multiplicand / dividend / mthi-mtlo data)
- b  input  32  rt operand (multiplier / divisor)
- flush  input  1  abort in-flight operation (exception/branch kill)
- hilo_req  input  1  decode stage holds mfhi/mflo/multu/divu/mthi/mtlo
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  multiply/divide in progress
- stall  output  1  busy & hilo_req; drives fetch/decode en low and decode/execute clr
- done  output  1  one-cycle pulse after HI/LO commit of multu/divu
- dz  output  1  last divu had b==0; sticky until next accepted start

## Operation
- States: IDLE, MUL, DIV. 5-bit iteration counter cnt. Working registers acc[31:0], q[31:0], m[31:0], kept separate from hi/lo.
- IDLE, start=1, op=00: m<=b, q<=a, acc<=0, cnt<=0, dz<=0, go MUL.
- IDLE, start=1, op=01: m<=b, q<=a, acc<=0, cnt<=0, dz<=(b==0), go DIV.
- IDLE, start=1, op=10: hi<=a. op=11: lo<=a. Stay IDLE; no busy, no done.
- MUL iteration: t[32:0] = acc + (q[0] ? m : 0); {acc,q} <= {t,q[31:1]} (33-bit sum, right shift of the 65-bit concatenation).
- DIV iteration (restoring): r[32:0] = {acc,q[31]} - {1'b0,m}. If r[32]==0: acc<=r[31:0], q<={q[30:0],1}; else acc<={acc[30:0],q[31]}, q<={q[30:0],0}.
- cnt increments each iteration. On the iteration with cnt==31, commit and return to IDLE: MUL sets hi<=acc_next and lo<=q_next; DIV sets hi<=remainder (acc_next) and lo<=quotient (q_next). done is set for the following cycle.
- Divide by zero runs the full 32 iterations and naturally yields lo=32'hFFFFFFFF, hi=a. dz=1.
- start while in MUL/DIV: ignored. The pipeline stall guarantees this does not occur legally.
- flush in MUL/DIV: return to IDLE on the next edge. hi/lo stay unchanged, done is not pulsed, and dz is cleared. flush in IDLE: no effect; flush has priority over start in the same cycle.
- Arithmetic is unsigned only; no overflow flag.

## Timing
- Reset values: hi=0, lo=0, busy=0, stall=0, done=0, dz=0, state IDLE, cnt=0.
- Reset asserted mid-operation aborts immediately. State and working registers clear; hi/lo are forced to 0.
- start sampled on edge T → busy=1 during cycles T+1..T+32. Iterations occur on edges T+1..T+32, with the commit on edge T+32.
- After edge T+32: busy=0, done=1 for exactly one cycle, and hi/lo hold the result. A new start is accepted in that done cycle.
- mthi/mtlo: hi/lo update on the sampling edge (1-cycle latency). done stays 0.
- busy, done and dz are registered. stall is combinational: busy & hilo_req.

## Test plan
- multu a=FFFFFFFF, b=FFFFFFFF → busy high for 32 cycles; then done pulse with hi=FFFFFFFE, lo=00000001.
- divu a=100, b=7 → lo=14, hi=2, dz=0 after 32 iterations. Back-to-back divu a=7, b=100 started in the done cycle → lo=0, hi=7.
- divu a=00001234, b=0 → lo=FFFFFFFF, hi=00001234, dz=1. The next multu 3×5 clears dz and gives hi=0, lo=15.
- Preload hi=AAAA via mthi. Run multu 2×3 and assert flush in iteration 10 → busy=0 next cycle, no done, hi=AAAA, lo unchanged.
- During multu, drive hilo_req=1 → stall=1 every busy cycle and 0 in the done cycle. A start pulse at iteration 5 is ignored; the result is unchanged.
- Assert reset low at iteration 20 of divu → all outputs 0 immediately. After release, mtlo a=5 → lo=5 after one edge.
